// File: rtl/packet_injector_pkg.sv
`default_nettype none
// ============================================================================
// Module   : packet_injector_pkg
// Purpose  : Shared types and default sizes for the packet injection stage.
// Revision : 1.0
// ============================================================================
package packet_injector_pkg;

    localparam int DEF_CHANNEL_WIDTH = 32;
    localparam int DEF_DATA_FLITS    = 4;
    localparam int DEF_QUEUE_DEPTH   = 4;
    localparam int DEF_CREDITS       = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } inj_state_e;

endpackage
`default_nettype wire

// File: rtl/packet_injector_queue.sv
`default_nettype none
// ============================================================================
// Module   : packet_injector_queue
// Purpose  : Circular packet FIFO with full/empty flags and occupancy count.
// Revision : 1.0
// ============================================================================
module packet_injector_queue
    import packet_injector_pkg::*;
#(
    parameter int WIDTH = DEF_CHANNEL_WIDTH * (DEF_DATA_FLITS + 1),
    parameter int DEPTH = DEF_QUEUE_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             w_push, w_pop;

    assign w_push  = push_i & (count_q != DEPTH_CNT);
    assign w_pop   = pop_i & (count_q != '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == DEPTH_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Payload storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/packet_injector.sv
`default_nettype none
// ============================================================================
// Module   : packet_injector
// Purpose  : Queues whole packets and serializes them flit-by-flit onto a
//            credit flow-controlled router channel.
// Revision : 1.0
// ============================================================================
module packet_injector
    import packet_injector_pkg::*;
#(
    parameter int CHANNEL_WIDTH = DEF_CHANNEL_WIDTH,
    parameter int DATA_FLITS    = DEF_DATA_FLITS,
    parameter int QUEUE_DEPTH   = DEF_QUEUE_DEPTH,
    parameter int CREDITS       = DEF_CREDITS,
    parameter int GAP_CYCLES    = 0
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      enable_in,
    input  logic [CHANNEL_WIDTH*(DATA_FLITS+1)-1:0]   packet_in,
    input  logic                                      packet_valid_in,
    output logic                                      packet_ready_out,
    output logic [CHANNEL_WIDTH-1:0]                  channel_out,
    output logic                                      valid_out,
    input  logic                                      credit_in,
    output logic                                      busy_out,
    output logic [31:0]                               injected_count_out,
    output logic                                      credit_error_out
);

    localparam int PKT_W  = CHANNEL_WIDTH * (DATA_FLITS + 1);
    localparam int CRW    = $clog2(CREDITS) + 1;
    localparam int IDX_W  = $clog2(DATA_FLITS + 1);
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int QCNT_W = $clog2(QUEUE_DEPTH) + 1;

    localparam logic [CRW-1:0]   CREDIT_MAX = CRW'(CREDITS);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DATA_FLITS - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD   = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    inj_state_e          state_q, state_d;
    logic [PKT_W-1:0]    shift_q, shift_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [CRW-1:0]      credits_q, credits_d;
    logic [CHANNEL_WIDTH-1:0] channel_q, channel_d;
    logic                valid_q;
    logic [31:0]         count_q, count_d;
    logic                cerr_q, cerr_d;
    logic                busy_q, busy_d;

    logic [PKT_W-1:0]    w_q_data;
    logic                w_q_full, w_q_empty, w_q_push;
    logic [QCNT_W-1:0]   w_q_count, w_occ_next;
    logic                w_has_credit, w_start, w_body, w_last, w_pop, w_send;

    assign w_q_push     = packet_valid_in & ~w_q_full;
    assign w_has_credit = (credits_q != '0);
    assign w_start      = (state_q == ST_IDLE) & ~w_q_empty & enable_in & w_has_credit;
    assign w_body       = (state_q == ST_SEND) & w_has_credit;
    assign w_last       = w_body & (idx_q == LAST_IDX);
    assign w_pop        = w_start;
    assign w_send       = w_start | w_body;
    assign w_occ_next   = w_q_count + QCNT_W'(w_q_push) - QCNT_W'(w_pop);

    packet_injector_queue #(
        .WIDTH (PKT_W),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk     (clk),
        .reset   (reset),
        .push_i  (w_q_push),
        .pop_i   (w_pop),
        .data_i  (packet_in),
        .data_o  (w_q_data),
        .full_o  (w_q_full),
        .empty_o (w_q_empty),
        .count_o (w_q_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (w_start) state_d = ST_SEND;
            ST_SEND: if (w_last)  state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
            ST_GAP:  if (gap_q == '0) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        shift_d   = shift_q;
        idx_d     = idx_q;
        gap_d     = gap_q;
        channel_d = channel_q;
        if (w_start) begin
            channel_d = w_q_data[PKT_W-1 -: CHANNEL_WIDTH];
            shift_d   = w_q_data << CHANNEL_WIDTH;
            idx_d     = '0;
        end else if (w_body) begin
            channel_d = shift_q[PKT_W-1 -: CHANNEL_WIDTH];
            shift_d   = shift_q << CHANNEL_WIDTH;
            idx_d     = idx_q + 1'b1;
            gap_d     = GAP_LOAD;
        end else if (state_q == ST_GAP && gap_q != '0) begin
            gap_d = gap_q - 1'b1;
        end

        // A credit returning on a send cycle cancels that send's debit.
        credits_d = credits_q;
        case ({w_send, credit_in})
            2'b10:   credits_d = credits_q - 1'b1;
            2'b01:   credits_d = (credits_q == CREDIT_MAX) ? credits_q : credits_q + 1'b1;
            default: credits_d = credits_q;
        endcase

        cerr_d  = cerr_q | (credit_in & (credits_q == CREDIT_MAX));
        count_d = count_q + {31'd0, w_last};
        busy_d  = (state_d != ST_IDLE) | (w_occ_next != '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q   <= '0;
            idx_q     <= '0;
            gap_q     <= '0;
            credits_q <= CREDIT_MAX;
            channel_q <= '0;
            valid_q   <= 1'b0;
            count_q   <= '0;
            cerr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            gap_q     <= gap_d;
            credits_q <= credits_d;
            channel_q <= channel_d;
            valid_q   <= w_send;
            count_q   <= count_d;
            cerr_q    <= cerr_d;
            busy_q    <= busy_d;
        end
    end

    assign packet_ready_out   = ~w_q_full;
    assign channel_out        = channel_q;
    assign valid_out          = valid_q;
    assign busy_out           = busy_q;
    assign injected_count_out = count_q;
    assign credit_error_out   = cerr_q;

endmodule
`default_nettype wire
